regfile_access_ctrl: RTL
========================

# regfile_access_ctrl

Controller in front of the 32x32 two-read/one-write register file. It shares the file's ports between the core pipeline and the debug module. It arbitrates reads with a starvation bound, and gives core writeback absolute priority on the write port. It also forwards same-cycle writes into read results, because the file's registered reads return pre-write data.

## Interface
- STARVE_MAX, default 8: consecutive lost read arbitrations after which a debug read is forced through.
- clk  in  1  system clock.
- rstN  in  1  asynchronous, active-low reset.
- core_rd_valid  in  1  core read request.
- core_rs1, core_rs2  in  5 each  core read addresses.
- core_rd_ready  out  1  core read issued this cycle.
- core_rdata_valid  out  1  core read data valid.
- core_rdata1, core_rdata2  out  32 each  core read data.
- core_wr_valid  in  1  writeback strobe; never stalled.
- core_wr_addr  in  5  writeback address.
- core_wr_data  in  32  writeback data.
- dbg_req_valid, dbg_req_ready  in/out  1  debug request handshake.
- dbg_req_we  in  1  1 = write, 0 = read.
- dbg_req_addr  in  5  debug address.
- dbg_req_wdata  in  32  debug write data.
- dbg_rsp_valid, dbg_rsp_ready  out/in  1  debug response handshake.
- dbg_rsp_rdata  out  32  debug read data; 0 for writes.
- rf_rs1, rf_rs2, rf_rd  out  5 each  drive the register file addresses.
- rf_we  out  1  register file write enable.
- rf_wdata  out  32  register file write data.
- rf_rdata1, rf_rdata2  in  32 each  register file outputs, 1-cycle latency.

## Operation
- **Debug FSM** (dbg_state_e): IDLE, GRANT_WAIT, READ_WAIT, RESP.
- **IDLE**
  - dbg_req_ready = 1.
  - On dbg_req_valid: latch we/addr/wdata, clear starve_cnt, go to GRANT_WAIT.
- **GRANT_WAIT, write request**
  - Granted when core_wr_valid = 0: rf_rd = addr, rf_we = 1, rf_wdata = wdata.
  - Then go to RESP with rdata = 0.
  - A write to x0 is still issued and acknowledged; the file drops it.
- **GRANT_WAIT, read request**
  - Granted when core_rd_valid = 0, or when starve_cnt == STARVE_MAX.
  - On grant: rf_rs2 = addr, core_rd_ready = 0, go to READ_WAIT.
  - When not granted: starve_cnt increments (saturating).
- **READ_WAIT**: capture rf_rdata2, through the bypass, into the rsp register; go to RESP.
- **RESP**: dbg_rsp_valid = 1; on dbg_rsp_ready go to IDLE.
- **Core reads**: when not stolen, rf_rs1/rf_rs2 = core_rs1/core_rs2 and core_rd_ready = 1.
- **Core writeback**: when core_wr_valid, rf_rd/rf_we/rf_wdata = core write, regardless of debug state.
- **Bypass**
  - Register the issued write (addr, data, we) alongside each issued read.
  - In the data cycle: if we && addr != 0 && addr == read addr, substitute the registered write data.
  - Applies per port, to both core and debug reads.
- **Reset**
  - Every registered output is 0: core_rdata_valid, core_rdata1/2, dbg_rsp_valid, dbg_rsp_rdata.
  - State returns to IDLE and starve_cnt to 0; an in-flight debug transaction is dropped with no response.
  - While rstN = 0, combinational outputs hold: rf_we = 0, dbg_req_ready = 0, core_rd_ready = 0.

## Timing
- Core read: issued at edge N (valid && ready), then core_rdata_valid = 1 with data for one cycle after edge N.
- Debug read: minimum 3 cycles from acceptance to dbg_rsp_valid (accept, grant, read-wait).
- Debug write: minimum 2 cycles from acceptance to dbg_rsp_valid.
- A forced debug read costs the core exactly one cycle of core_rd_ready = 0.
- Only one debug transaction is outstanding; dbg_req_ready = 0 outside IDLE.
- Debug write and core writeback in the same cycle: core wins, and the debug write retries the next cycle.
- Debug read and core write to the same address in the same cycle: the debug response returns the new data (bypass).

## Configuration
- REGFILE_BYPASS_EN defined: forwarding as above.
- Not defined: raw rf_rdata is returned, and a read in the same cycle as a write to the same address returns the old value.

## Structure
- Package regfile_ctrl_pkg holds:
  - XLEN = 32
  - REG_ADDR_W = 5
  - dbg_state_e
  - typedef wr_req_t (we, addr, data)
- Sub-module regfile_bypass: registers one wr_req_t plus a read address, and outputs the forwarded data. It is instantiated twice: for port 1, and for port 2 shared between core and debug.

## Test plan
- Core reads x5 with no contention → core_rdata_valid one cycle after issue; core_rdata1 = value written to x5 earlier.
- Core writes x7 = 0xDEADBEEF while reading rs1 = 7 in the same cycle → core_rdata1 = 0xDEADBEEF with REGFILE_BYPASS_EN, old value without it.
- Debug read of x3 while core_rd_valid is held high → forced grant after exactly STARVE_MAX = 8 waiting cycles; core_rd_ready low for one cycle; dbg_rsp_rdata = x3 contents.
- Debug write x0 = 0x1234, then debug read x0 → write acknowledged; read returns 0.
- Debug write x9 during continuous core_wr_valid → stalls until core_wr_valid drops; the following read of x9 returns the debug value.
- rstN pulsed low in READ_WAIT → dbg_rsp_valid stays 0, state IDLE, starve_cnt 0, and a new request is accepted after reset.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register file access controller.
// Build option: REGFILE_BYPASS_EN enables same-cycle write forwarding.
package regfile_ctrl_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      StIdle,
      StGrantWait,
      StReadWait,
      StResp
   } dbg_state_e;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wr_req_t;

endpackage

// File: rtl/regfile_bypass.sv
// One read port's forwarding stage: remembers the write and read address of the issue cycle.
// With REGFILE_BYPASS_EN undefined the raw file data passes straight through.
module regfile_bypass
   import regfile_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstN,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  wr_req_t               wr_i,
   input  logic [XLEN-1:0]       rf_rdata_i,
   output logic [XLEN-1:0]       rdata_o
);

   logic [REG_ADDR_W-1:0] rd_addr_q;
   wr_req_t               wr_q;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rd_addr_q <= '0;
         wr_q      <= '0;
      end else begin
         rd_addr_q <= rd_addr_i;
         wr_q      <= wr_i;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // The file returns pre-write data, so a matching write from the issue cycle wins.
   always_comb begin
      rdata_o = rf_rdata_i;
      if (wr_q.we && (wr_q.addr != '0) && (wr_q.addr == rd_addr_q)) begin
         rdata_o = wr_q.data;
      end
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{rd_addr_q, wr_q};
   assign rdata_o       = rf_rdata_i;
`endif

endmodule

// File: rtl/regfile_access_ctrl.sv
// Shares the 2R/1W register file between core pipeline and debug module.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writes into read data.
module regfile_access_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  core_rd_valid,
   input  logic [REG_ADDR_W-1:0] core_rs1,
   input  logic [REG_ADDR_W-1:0] core_rs2,
   output logic                  core_rd_ready,
   output logic                  core_rdata_valid,
   output logic [XLEN-1:0]       core_rdata1,
   output logic [XLEN-1:0]       core_rdata2,
   input  logic                  core_wr_valid,
   input  logic [REG_ADDR_W-1:0] core_wr_addr,
   input  logic [XLEN-1:0]       core_wr_data,
   input  logic                  dbg_req_valid,
   output logic                  dbg_req_ready,
   input  logic                  dbg_req_we,
   input  logic [REG_ADDR_W-1:0] dbg_req_addr,
   input  logic [XLEN-1:0]       dbg_req_wdata,
   output logic                  dbg_rsp_valid,
   input  logic                  dbg_rsp_ready,
   output logic [XLEN-1:0]       dbg_rsp_rdata,
   output logic [REG_ADDR_W-1:0] rf_rs1,
   output logic [REG_ADDR_W-1:0] rf_rs2,
   output logic [REG_ADDR_W-1:0] rf_rd,
   output logic                  rf_we,
   output logic [XLEN-1:0]       rf_wdata,
   input  logic [XLEN-1:0]       rf_rdata1,
   input  logic [XLEN-1:0]       rf_rdata2
);

   localparam int unsigned     CntW        = $clog2(STARVE_MAX + 2);
   localparam logic [CntW-1:0] StarveLimit = CntW'(STARVE_MAX);

   dbg_state_e            state_q, state_d;
   logic [CntW-1:0]       starve_q, starve_d;
   logic                  req_we_q;
   logic [REG_ADDR_W-1:0] req_addr_q;
   logic [XLEN-1:0]       req_wdata_q;
   logic [XLEN-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic                  core_vld_q;
   logic                  accept, dbg_rd_grant, dbg_wr_grant;
   wr_req_t               wr_issue;
   logic [XLEN-1:0]       fwd1, fwd2;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= StIdle;
         starve_q    <= '0;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         rsp_rdata_q <= '0;
         core_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         rsp_rdata_q <= rsp_rdata_d;
         core_vld_q  <= core_rd_valid & core_rd_ready;
         if (accept) begin
            req_we_q    <= dbg_req_we;
            req_addr_q  <= dbg_req_addr;
            req_wdata_q <= dbg_req_wdata;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      starve_d      = starve_q;
      rsp_rdata_d   = rsp_rdata_q;
      accept        = 1'b0;
      dbg_rd_grant  = 1'b0;
      dbg_wr_grant  = 1'b0;
      dbg_req_ready = 1'b0;
      case (state_q)
         StIdle: begin
            dbg_req_ready = rstN;
            if (dbg_req_valid) begin
               accept   = 1'b1;
               starve_d = '0;
               state_d  = StGrantWait;
            end
         end
         StGrantWait: begin
            if (req_we_q) begin
               // Core writeback always owns the write port; debug retries next cycle.
               if (!core_wr_valid) begin
                  dbg_wr_grant = 1'b1;
                  rsp_rdata_d  = '0;
                  state_d      = StResp;
               end
            end else if (!core_rd_valid || (starve_q == StarveLimit)) begin
               dbg_rd_grant = 1'b1;
               state_d      = StReadWait;
            end else if (starve_q != StarveLimit) begin
               starve_d = starve_q + 1'b1;
            end
         end
         StReadWait: begin
            rsp_rdata_d = fwd2;
            state_d     = StResp;
         end
         StResp: begin
            if (dbg_rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wr_issue = '0;
      if (core_wr_valid) begin
         wr_issue = '{we: 1'b1, addr: core_wr_addr, data: core_wr_data};
      end else if (dbg_wr_grant) begin
         wr_issue = '{we: 1'b1, addr: req_addr_q, data: req_wdata_q};
      end
      if (!rstN) wr_issue.we = 1'b0;
   end

   assign rf_we    = wr_issue.we;
   assign rf_rd    = wr_issue.addr;
   assign rf_wdata = wr_issue.data;

   // A granted debug read steals port 2 for one cycle.
   assign core_rd_ready = rstN & ~dbg_rd_grant;
   assign rf_rs1        = core_rs1;
   assign rf_rs2        = dbg_rd_grant ? req_addr_q : core_rs2;

   regfile_bypass u_bypass1 (
      .clk        (clk),
      .rstN       (rstN),
      .rd_addr_i  (rf_rs1),
      .wr_i       (wr_issue),
      .rf_rdata_i (rf_rdata1),
      .rdata_o    (fwd1)
   );

   regfile_bypass u_bypass2 (
      .clk        (clk),
      .rstN       (rstN),
      .rd_addr_i  (rf_rs2),
      .wr_i       (wr_issue),
      .rf_rdata_i (rf_rdata2),
      .rdata_o    (fwd2)
   );

   assign core_rdata_valid = core_vld_q;
   assign core_rdata1      = core_vld_q ? fwd1 : '0;
   assign core_rdata2      = core_vld_q ? fwd2 : '0;
   assign dbg_rsp_valid    = (state_q == StResp);
   assign dbg_rsp_rdata    = rsp_rdata_q;

endmodule
